// File: rtl/tick_sched_pkg.sv
// Shared constants for the tick scheduler: clock rate, common periods and
// the default counter width.
package tick_sched_pkg;

    localparam int unsigned CLK_HZ               = 100000000;
    localparam int unsigned PERIOD_1S            = 100000000;
    localparam int unsigned PERIOD_100MS         = 10000000;
    localparam int unsigned PERIOD_1MS           = 100000;
    localparam int unsigned PERIOD_10US          = 1000;
    localparam int unsigned PERIOD_1US           = 100;
    localparam int unsigned DEFAULT_PERIOD_WIDTH = 27;

endpackage

// File: rtl/tick_channel.sv
// One scheduler channel: period register, down-counter, run status and the
// pending/overrun flags for its expired ticks.
module tick_channel #(
    parameter int unsigned PERIOD_WIDTH = 27
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we_i,
    input  logic [PERIOD_WIDTH-1:0] cfg_period_i,
    input  logic                    cfg_enable_i,
    input  logic                    cfg_oneshot_i,
    input  logic                    grant_i,
    input  logic                    overrun_clr,
    output logic                    expire_o,
    output logic                    pending_o,
    output logic                    active_o,
    output logic                    overrun_o
);

    localparam logic [PERIOD_WIDTH-1:0] ONE = PERIOD_WIDTH'(1);

    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic                    oneshot_q, oneshot_d;
    logic                    active_q, active_d;
    logic                    pending_q, pending_d;
    logic                    overrun_q, overrun_d;
    logic                    expire;

    always_comb begin
        period_d  = period_q;
        cnt_d     = cnt_q;
        oneshot_d = oneshot_q;
        active_d  = active_q;
        pending_d = pending_q;
        overrun_d = overrun_q && !overrun_clr;
        // A config write on the same cycle suppresses the expiry.
        expire    = active_q && (cnt_q == '0) && !cfg_we_i;

        if (cfg_we_i) begin
            period_d  = cfg_period_i;
            oneshot_d = cfg_oneshot_i;
            active_d  = cfg_enable_i && (cfg_period_i != '0);
            cnt_d     = (cfg_period_i != '0) ? (cfg_period_i - ONE) : '0;
            pending_d = active_d ? (pending_q && !grant_i) : 1'b0;
        end else begin
            if (active_q) begin
                if (cnt_q == '0) begin
                    if (oneshot_q) begin
                        active_d = 1'b0;
                    end else begin
                        cnt_d = period_q - ONE;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            pending_d = (pending_q && !grant_i) || expire;
        end

        if (expire && pending_q && !grant_i) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period_q  <= '0;
            cnt_q     <= '0;
            oneshot_q <= 1'b0;
            active_q  <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            period_q  <= period_d;
            cnt_q     <= cnt_d;
            oneshot_q <= oneshot_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign expire_o  = expire;
    assign pending_o = pending_q;
    assign active_o  = active_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel tick scheduler: per-channel timers feed a round-robin
// arbiter that presents one tick at a time on a valid/ready output.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned PERIOD_WIDTH = DEFAULT_PERIOD_WIDTH,
    parameter int unsigned ID_WIDTH     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [ID_WIDTH-1:0]     cfg_chan,
    input  logic [PERIOD_WIDTH-1:0] cfg_period,
    input  logic                    cfg_enable,
    input  logic                    cfg_oneshot,
    output logic                    tick_valid,
    output logic [ID_WIDTH-1:0]     tick_chan,
    input  logic                    tick_ready,
    output logic [CHANNELS-1:0]     active,
    output logic [CHANNELS-1:0]     pending,
    output logic [CHANNELS-1:0]     overrun,
    input  logic                    overrun_clr
);

    logic [CHANNELS-1:0] chan_we;
    logic [CHANNELS-1:0] grant;
    logic [CHANNELS-1:0] expire;

    logic                tick_valid_q, tick_valid_d;
    logic [ID_WIDTH-1:0] tick_chan_q, tick_chan_d;
    logic [ID_WIDTH-1:0] ptr_q, ptr_d;
    logic                found;
    int unsigned         idx;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        assign chan_we[i] = cfg_we && (cfg_chan == ID_WIDTH'(i));

        tick_channel #(
            .PERIOD_WIDTH(PERIOD_WIDTH)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .cfg_we_i     (chan_we[i]),
            .cfg_period_i (cfg_period),
            .cfg_enable_i (cfg_enable),
            .cfg_oneshot_i(cfg_oneshot),
            .grant_i      (grant[i]),
            .overrun_clr  (overrun_clr),
            .expire_o     (expire[i]),
            .pending_o    (pending[i]),
            .active_o     (active[i]),
            .overrun_o    (overrun[i])
        );
    end

    // Search starts one past the last granted channel and wraps around.
    always_comb begin
        tick_valid_d = tick_valid_q;
        tick_chan_d  = tick_chan_q;
        ptr_d        = ptr_q;
        grant        = '0;
        found        = 1'b0;
        idx          = 0;

        if (!tick_valid_q || tick_ready) begin
            tick_valid_d = 1'b0;
            for (int unsigned off = 1; off <= CHANNELS; off++) begin
                idx = (32'(ptr_q) + off) % CHANNELS;
                if (!found && pending[idx]) begin
                    found        = 1'b1;
                    grant[idx]   = 1'b1;
                    tick_valid_d = 1'b1;
                    tick_chan_d  = ID_WIDTH'(idx);
                    ptr_d        = ID_WIDTH'(idx);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_valid_q <= 1'b0;
            tick_chan_q  <= '0;
            ptr_q        <= ID_WIDTH'(CHANNELS - 1);
        end else begin
            tick_valid_q <= tick_valid_d;
            tick_chan_q  <= tick_chan_d;
            ptr_q        <= ptr_d;
        end
    end

    assign tick_valid = tick_valid_q;
    assign tick_chan  = tick_chan_q;

endmodule
